// File: rtl/inst_rom_axi.sv
// -----------------------------------------------------------------------------
// inst_rom_axi
//
// Read-only AXI4 slave over a single-port word memory, used as an
// instruction ROM. The memory is filled through a separate preload port and
// read back through the AXI read channels (AR/R) as FIXED or INCR bursts.
//
// Ports
//   CLK        sole clock, rising edge
//   RST        synchronous active-low reset
//   ARID       read transaction ID, echoed on RID
//   ARADDR     byte address of the first beat (bits [1:0] ignored)
//   ARLEN      number of beats minus one
//   ARBURST    2'b00 FIXED, any other value INCR
//   ARVALID    address valid
//   ARREADY    address accept (high only while idle)
//   RID        captured ARID
//   RDATA      read data (zero on SLVERR beats)
//   RRESP      2'b00 OKAY, 2'b10 SLVERR (address beyond memory)
//   RLAST      final beat marker
//   RVALID     read data valid
//   RREADY     master accepts read data
//   LOAD_EN    preload write strobe
//   LOAD_ADDR  preload word index
//   LOAD_DATA  preload word
//   DBG_STATE  current FSM state (0 IDLE, 1 FETCH, 2 DATA)
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both 1. Once RVALID is raised, RDATA/RRESP/RLAST/RID stay constant until
// the edge on which RREADY is also 1; RVALID never drops without that
// handshake, except on reset.
//
// Timing: every beat costs two cycles. The FETCH state performs the
// synchronous memory read into the output registers, the DATA state presents
// the beat until it is accepted. The first RVALID appears two cycles after
// the cycle in which the AR handshake occurs.
// -----------------------------------------------------------------------------
module inst_rom_axi #(
    parameter int C_S_AXI_ID_WIDTH = 1,
    parameter int C_MEM_WORDS_LOG2 = 12
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [C_S_AXI_ID_WIDTH-1:0] ARID,
    input  logic [31:0]                 ARADDR,
    input  logic [7:0]                  ARLEN,
    input  logic [1:0]                  ARBURST,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0] RID,
    output logic [31:0]                 RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic                        LOAD_EN,
    input  logic [C_MEM_WORDS_LOG2-1:0] LOAD_ADDR,
    input  logic [31:0]                 LOAD_DATA,
    output logic [1:0]                  DBG_STATE
);

    localparam int DEPTH = 1 << C_MEM_WORDS_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] mem [DEPTH];

    // Burst context captured on the AR handshake
    logic [C_MEM_WORDS_LOG2-1:0] idx;
    logic [7:0]                  len;
    logic [7:0]                  beat;
    logic                        fixed;
    logic                        err;

    logic ar_hs;
    logic r_hs;
    logic capture;
    logic fetch;
    logic advance;
    logic addr_err;

    assign ar_hs     = ARVALID && ARREADY;
    assign r_hs      = RVALID && RREADY;
    assign DBG_STATE = state;

    // Any address bit above the memory span makes the whole burst an error
    assign addr_err = |(ARADDR >> (C_MEM_WORDS_LOG2 + 2));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ar_hs) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DATA;
            end
            S_DATA: begin
                if (r_hs) begin
                    state_next = RLAST ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output strobes
    // -------------------------------------------------------------------------
    always_comb begin
        capture = 1'b0;
        fetch   = 1'b0;
        advance = 1'b0;
        case (state)
            S_IDLE:  capture = ar_hs;
            S_FETCH: fetch   = 1'b1;
            S_DATA:  advance = r_hs;
            default: begin
                capture = 1'b0;
                fetch   = 1'b0;
                advance = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Preload port. Runs regardless of FSM state or reset so that reset never
    // disturbs the memory image. A write and a FETCH read of the same word on
    // the same edge return the old word (read-first) because both sample the
    // array before the non-blocking update lands.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (LOAD_EN) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    // -------------------------------------------------------------------------
    // AR acceptance. ARREADY is registered from the next state so that it
    // stays low while reset is held and rises on the first edge after release.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ARREADY <= 1'b0;
        end else begin
            ARREADY <= (state_next == S_IDLE);
        end
    end

    // -------------------------------------------------------------------------
    // Burst context
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            idx   <= '0;
            len   <= '0;
            beat  <= '0;
            fixed <= 1'b0;
            err   <= 1'b0;
            RID   <= '0;
        end else if (capture) begin
            idx   <= ARADDR[C_MEM_WORDS_LOG2+1:2];
            len   <= ARLEN;
            beat  <= '0;
            fixed <= (ARBURST == 2'b00);
            err   <= addr_err;
            RID   <= ARID;
        end else if (advance) begin
            beat <= beat + 8'd1;
            // Natural overflow of idx gives the modulo-depth wrap
            if (!fixed) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read data path. Loaded only in FETCH, so the beat is frozen for the
    // whole time it sits in DATA waiting for RREADY.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            RDATA  <= '0;
            RRESP  <= 2'b00;
            RLAST  <= 1'b0;
            RVALID <= 1'b0;
        end else if (fetch) begin
            RDATA  <= err ? 32'h0 : mem[idx];
            RRESP  <= err ? 2'b10 : 2'b00;
            RLAST  <= (beat == len);
            RVALID <= 1'b1;
        end else if (advance) begin
            RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_rom_axi.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_axi
//
// Bench for inst_rom_axi at default parameters. The memory image is mirrored
// in mem_model; each burst is expanded into its expected beats (data, resp,
// last) from the address, length and burst type, and the beats returned by
// the design are matched against that queue in order.
// -----------------------------------------------------------------------------
module tb_inst_rom_axi;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          CLK;
  logic          RST;
  logic [0:0]    ARID;
  logic [31:0]   ARADDR;
  logic [7:0]    ARLEN;
  logic [1:0]    ARBURST;
  logic          ARVALID;
  logic          ARREADY;
  logic [0:0]    RID;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;
  logic          LOAD_EN;
  logic [AW-1:0] LOAD_ADDR;
  logic [31:0]   LOAD_DATA;
  logic [1:0]    dbg_state;

  inst_rom_axi #(
    .C_S_AXI_ID_WIDTH(1),
    .C_MEM_WORDS_LOG2(AW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ARID     (ARID),
    .ARADDR   (ARADDR),
    .ARLEN    (ARLEN),
    .ARBURST  (ARBURST),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RID      (RID),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RLAST    (RLAST),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .LOAD_EN  (LOAD_EN),
    .LOAD_ADDR(LOAD_ADDR),
    .LOAD_DATA(LOAD_DATA),
    .DBG_STATE(dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard: {resp[1:0], last, data[31:0]}
  logic [34:0] exp_q[$];
  logic [31:0] mem_model [DEPTH];
  int n_checks;
  int n_fail;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    LOAD_EN   = 1'b1;
    LOAD_ADDR = a[AW-1:0];
    LOAD_DATA = d;
    tick();
    LOAD_EN   = 1'b0;
    mem_model[a] = d;
  endtask

  // Waits (bounded) for ARREADY, then presents one AR beat for one edge.
  task automatic send_ar(input logic id, input logic [31:0] addr, input int len,
                         input bit fixed, output bit ok);
    int w;
    w = 0;
    while (ARREADY !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n_checks++;
    if (ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_wait: ARREADY=%b after %0d cycles, expected 1", ARREADY, w);
      ok = 1'b0;
      return;
    end
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = len[7:0];
    ARBURST = fixed ? 2'b00 : 2'(1 + $urandom_range(0, 2));
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    ok = 1'b1;
  endtask

  // Full burst: builds expectations, issues AR, checks latency, drains beats.
  task automatic read_burst(input logic id, input logic [31:0] addr, input int len,
                            input bit fixed, input int stall_beat, input int stall_len,
                            input bit rand_ready, input bit collide);
    int base;
    bit err;
    bit ok;
    bit hs;
    int bi;
    int cyc;
    int stall_left;
    logic [34:0] e;
    logic [31:0] new_word;

    base = int'(addr[AW+1:2]);
    err  = (addr[31:AW+2] != '0);
    exp_q.delete();
    for (int i = 0; i <= len; i++) begin
      int widx;
      widx = fixed ? base : (base + i) % DEPTH;
      exp_q.push_back({err ? 2'b10 : 2'b00, (i == len), err ? 32'h0 : mem_model[widx]});
    end

    send_ar(id, addr, len, fixed, ok);
    if (!ok) return;

    // Cycle after the handshake: nothing valid yet
    n_checks++;
    if (RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: RVALID=%b one cycle after AR, expected 0", RVALID);
    end
    if (collide) begin
      new_word  = ~mem_model[base];
      LOAD_EN   = 1'b1;
      LOAD_ADDR = base[AW-1:0];
      LOAD_DATA = new_word;
    end
    tick();
    if (collide) begin
      LOAD_EN = 1'b0;
      mem_model[base] = new_word;
    end
    n_checks++;
    if (RVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_first: RVALID=%b two cycles after AR, expected 1", RVALID);
    end

    bi = 0;
    cyc = 0;
    stall_left = stall_len;
    while (exp_q.size() > 0 && cyc < 300) begin
      if (RVALID === 1'b1) begin
        e = exp_q[0];
        n_checks++;
        if ({RRESP, RLAST, RDATA} !== e || RID !== id) begin
          n_fail++;
          $display("FAIL beat_%0d: got resp=%0h last=%0b data=%08h id=%0h, expected resp=%0h last=%0b data=%08h id=%0h",
                   bi, RRESP, RLAST, RDATA, RID, e[34:33], e[32], e[31:0], id);
        end
        if (bi == stall_beat && stall_left > 0) begin
          RREADY = 1'b0;
          stall_left--;
        end else if (rand_ready) begin
          RREADY = 1'($urandom_range(0, 1));
        end else begin
          RREADY = 1'b1;
        end
      end else begin
        RREADY = 1'($urandom_range(0, 1));
      end
      hs = (RVALID === 1'b1) && RREADY;
      tick();
      cyc++;
      if (hs) begin
        void'(exp_q.pop_front());
        bi++;
        // One bubble cycle between beats
        if (exp_q.size() > 0) begin
          n_checks++;
          if (RVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL beat_gap_%0d: RVALID=%b after handshake, expected 0", bi, RVALID);
          end
        end
      end
    end
    RREADY = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL burst_timeout: %0d beats missing, expected 0", exp_q.size());
    end
    n_checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_end: ARREADY=%b RVALID=%b, expected 1 0", ARREADY, RVALID);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({ARREADY, RVALID, RLAST, RRESP, RID, RDATA} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ARREADY=%b RVALID=%b RLAST=%b RRESP=%0h RID=%0h RDATA=%08h, expected all 0",
               ARREADY, RVALID, RLAST, RRESP, RID, RDATA);
    end
    RST = 1'b1;
    tick();
    n_checks++;
    if (ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: ARREADY=%b, expected 1", ARREADY);
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
    for (int i = 0; i < 4; i++) load_word(i, 32'h100 + i);
    load_word(5, 32'hCAFE_0005);
  endtask

  task automatic test_incr_basic();
    read_burst(1'b1, 32'h0, 3, 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    read_burst(1'b1, 32'h0, 3, 1'b0, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    read_burst(1'b0, 32'h3FFC, 1, 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_slverr();
    read_burst(1'b1, 32'h4000, 2, 1'b0, -1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_read_first();
    read_burst(1'b0, 32'h40, 0, 1'b0, -1, 0, 1'b0, 1'b1);
    // The new word must be visible to the next read
    read_burst(1'b1, 32'h40, 0, 1'b1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_fixed_reset();
    bit ok;
    send_ar(1'b0, 32'h14, 2, 1'b1, ok);
    if (!ok) return;
    tick();
    n_checks++;
    if (RVALID !== 1'b1 || RDATA !== mem_model[5] || RLAST !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_beat0: RVALID=%b RDATA=%08h RLAST=%b, expected 1 %08h 0",
               RVALID, RDATA, RLAST, mem_model[5]);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    tick();
    n_checks++;
    if (RVALID !== 1'b1 || RDATA !== mem_model[5]) begin
      n_fail++;
      $display("FAIL fixed_beat1: RVALID=%b RDATA=%08h, expected 1 %08h", RVALID, RDATA, mem_model[5]);
    end
    RST = 1'b0;
    tick();
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: RVALID=%b ARREADY=%b, expected 0 0", RVALID, ARREADY);
    end
    RST = 1'b1;
    tick();
    n_checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: ARREADY=%b RVALID=%b, expected 1 0", ARREADY, RVALID);
    end
    read_burst(1'b1, 32'h14, 0, 1'b1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 5) == 0) a = $urandom | 32'h0001_0000;
      else a = 32'($urandom_range(0, 32'h3FFF));
      read_burst(1'($urandom_range(0, 1)), a, $urandom_range(0, 7),
                 1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST       = 1'b0;
    ARID      = '0;
    ARADDR    = '0;
    ARLEN     = '0;
    ARBURST   = 2'b01;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    LOAD_EN   = 1'b0;
    LOAD_ADDR = '0;
    LOAD_DATA = '0;

    test_reset();
    test_preload();
    test_incr_basic();
    test_backpressure();
    test_wrap();
    test_slverr();
    test_read_first();
    test_fixed_reset();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_axi.md
INST_ROM_AXI -- requirements
Module: inst_rom_axi

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter C_MEM_WORDS_LOG2, default 12, log2 of memory depth in 32-bit words.
REQ-003 SHALL have port CLK, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-low reset: sampled on the CLK edge, asserted when 0.
REQ-005 SHALL have port ARID, input, C_S_AXI_ID_WIDTH, read transaction ID.
REQ-006 SHALL have port ARADDR, input, 32, byte address of the first beat.
REQ-007 SHALL have port ARLEN, input, 8, beats minus one.
REQ-008 SHALL have port ARBURST, input, 2, 2'b00 FIXED; any other value INCR.
REQ-009 SHALL have port ARVALID, input, 1, address valid.
REQ-010 SHALL have port ARREADY, output, 1, address accept.
REQ-011 SHALL have port RID, output, C_S_AXI_ID_WIDTH, echo of the captured ARID.
REQ-012 SHALL have port RDATA, output, 32, read data.
REQ-013 SHALL have port RRESP, output, 2, 2'b00 OKAY or 2'b10 SLVERR.
REQ-014 SHALL have port RLAST, output, 1, final beat marker.
REQ-015 SHALL have port RVALID, output, 1, data valid.
REQ-016 SHALL have port RREADY, input, 1, master accepts data.
REQ-017 SHALL have port LOAD_EN, input, 1, preload write strobe.
REQ-018 SHALL have port LOAD_ADDR, input, C_MEM_WORDS_LOG2, preload word index.
REQ-019 SHALL have port LOAD_DATA, input, 32, preload word.

Function
REQ-020 SHALL hold 2^C_MEM_WORDS_LOG2 x 32-bit words; word index = ARADDR[C_MEM_WORDS_LOG2+1:2]; ARADDR[1:0] ignored.
REQ-021 SHALL write LOAD_DATA to LOAD_ADDR on every edge with LOAD_EN=1, independent of the FSM state.
REQ-022 SHALL use FSM IDLE -> FETCH -> DATA; IDLE->FETCH on ARVALID&&ARREADY; FETCH->DATA unconditionally; DATA->FETCH on RVALID&&RREADY with beats remaining; DATA->IDLE on RVALID&&RREADY&&RLAST.
REQ-023 SHALL drive ARREADY=1 exactly while in IDLE; SHALL capture ARID, index, ARLEN and burst type on the AR handshake.
REQ-024 SHALL raise RVALID 2 cycles after the AR handshake edge; each later beat SHALL become valid 2 cycles after the previous beat's handshake, giving 1 beat per 2 cycles.
REQ-025 SHALL hold RDATA, RRESP, RLAST and RID stable while RVALID=1 and RREADY=0.
REQ-026 SHALL increment the index by 1 per accepted beat for INCR, wrapping modulo 2^C_MEM_WORDS_LOG2; SHALL keep the index constant for FIXED.
REQ-027 SHALL assert RLAST on beat number ARLEN (0-based); ARLEN=0 gives a single beat with RLAST=1.
REQ-028 SHALL return RRESP=2'b10 and RDATA=0 for every beat when ARADDR[31:C_MEM_WORDS_LOG2+2] is nonzero at capture; otherwise RRESP=2'b00; the full ARLEN+1 beats SHALL be returned in both cases.
REQ-029 SHALL return the old word when a LOAD_EN write and a FETCH read hit the same index on the same edge (read-first).

Reset
REQ-030 SHALL, on any edge with RST=0, force state IDLE and ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0.
REQ-031 SHALL drive ARREADY=1 on the first edge after RST returns to 1.
REQ-032 SHALL abort any burst in progress on reset, drop RVALID at that edge, and leave memory contents unchanged.

Verification
REQ-033 Preload 0x100..0x103 at words 0..3; AR ARADDR=0x0, ARLEN=3, INCR, ARID=1, RREADY=1 -> 4 beats 0x100..0x103, RID=1, RLAST on the 4th beat only, first RVALID 2 cycles after AR.
REQ-034 Same burst with RREADY=0 for 5 cycles on beat 2 -> RDATA=0x101 held stable throughout; burst completes normally.
REQ-035 ARADDR=0x3FFC (last word at default depth), ARLEN=1, INCR -> beats word 4095 then word 0.
REQ-036 ARADDR=0x4000, ARLEN=2 -> 3 beats, RRESP=2'b10, RDATA=0, RLAST on the 3rd beat; ARREADY=1 again afterwards.
REQ-037 FIXED burst at word 5, ARLEN=2 -> 3 identical beats; RST=0 during the 2nd beat -> RVALID=0 at that edge, ARREADY=1 one edge after release, preloaded word 5 still readable.
